mem_io_responder: RTL and testbench

- Byte-wide memory/IO responder on the far side of the memory-controller RAM port. It accepts one address, write flag and data byte per cycle and returns read data one cycle later.
- Addresses with bits [17:16]==2'b11 route to the IO space:
  - a TX FIFO toward the UART;
  - an RX FIFO from the UART;
  - a halt register.
- It drives the uart-full indication that the controller uses to throttle IO writes.

---
 rtl/mem_io_responder_if.sv | 30 +++
 rtl/mem_io_responder.sv | 135 +++++++++++++
 tb/tb_mem_io_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-wide RAM port plus UART TX/RX byte streams between controller, responder and UART.
interface mem_io_responder_if;
   logic        in_ram_write_flag;
   logic [31:0] in_ram_address;
   logic [7:0]  in_ram_data;
   logic [7:0]  out_ram_data;
   logic        out_uart_full;
   logic [7:0]  out_tx_data;
   logic        out_tx_valid;
   logic        in_tx_ready;
   logic [7:0]  in_rx_data;
   logic        in_rx_valid;
   logic        out_rx_full;
   logic        out_overflow;
   logic        out_halt;

   modport slave (
      input  in_ram_write_flag, in_ram_address, in_ram_data,
      input  in_tx_ready, in_rx_data, in_rx_valid,
      output out_ram_data, out_uart_full, out_tx_data, out_tx_valid,
      output out_rx_full, out_overflow, out_halt
   );

   modport master (
      output in_ram_write_flag, in_ram_address, in_ram_data,
      output in_tx_ready, in_rx_data, in_rx_valid,
      input  out_ram_data, out_uart_full, out_tx_data, out_tx_valid,
      input  out_rx_full, out_overflow, out_halt
   );
endinterface

// File: rtl/mem_io_responder.sv
// RAM/IO responder: byte RAM, UART TX/RX FIFOs and halt flag; TX_LOOPBACK_EN echoes TX pops into RX.
// Read data registered (1 cycle); out_uart_full throttles IO writes, full-FIFO TX writes are dropped.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH       = 8,
   parameter int RX_DEPTH       = 8
) (
   input  logic clk,
   input  logic rst,
   mem_io_responder_if.slave mem_if
);
   localparam int TPW = $clog2(TX_DEPTH);
   localparam int TCW = TPW + 1;
   localparam int RPW = $clog2(RX_DEPTH);
   localparam int RCW = RPW + 1;
   localparam logic [15:0] OFF_UART = 16'h0000;
   localparam logic [15:0] OFF_HALT = 16'h0004;

   logic [7:0] ram    [0:(2**RAM_ADDR_WIDTH)-1];
   logic [7:0] tx_mem [0:TX_DEPTH-1];
   logic [7:0] rx_mem [0:RX_DEPTH-1];

   logic [TPW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
   logic [TCW-1:0] tx_count_q, tx_count_d;
   logic [RPW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
   logic [RCW-1:0] rx_count_q, rx_count_d;
   logic [7:0]     ram_rd_q, ram_rd_d;
   logic           uart_full_q, uart_full_d;
   logic           rx_full_q, rx_full_d;
   logic           overflow_q, overflow_d;
   logic           halt_q, halt_d;

   logic                      wr, io_sel, uart_sel, halt_sel, ram_we;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;
   logic                      tx_push_req, tx_push, tx_pop;
   logic [7:0]                tx_head;
   logic                      rx_push_src, rx_push, rx_pop;
   logic [7:0]                rx_push_dat;
   logic                      unused_addr;

   assign wr          = mem_if.in_ram_write_flag;
   assign io_sel      = (mem_if.in_ram_address[17:16] == 2'b11);
   assign uart_sel    = io_sel && (mem_if.in_ram_address[15:0] == OFF_UART);
   assign halt_sel    = io_sel && (mem_if.in_ram_address[15:0] == OFF_HALT);
   assign ram_idx     = mem_if.in_ram_address[RAM_ADDR_WIDTH-1:0];
   assign ram_we      = wr && !io_sel;
   assign unused_addr = ^mem_if.in_ram_address[31:18];

   // A full TX FIFO still accepts a write when its head leaves in the same cycle.
   assign tx_head     = tx_mem[tx_rd_ptr_q];
   assign tx_pop      = (tx_count_q != '0) && mem_if.in_tx_ready;
   assign tx_push_req = wr && uart_sel;
   assign tx_push     = tx_push_req && ((tx_count_q != TCW'(TX_DEPTH)) || tx_pop);
   assign tx_count_d  = tx_count_q + TCW'(tx_push) - TCW'(tx_pop);
   assign uart_full_d = (tx_count_d >= TCW'(TX_DEPTH - 1));
   assign overflow_d  = overflow_q || (tx_push_req && !tx_push);
   assign halt_d      = halt_q || (wr && halt_sel);

`ifdef TX_LOOPBACK_EN
   assign rx_push_src = tx_pop || mem_if.in_rx_valid;
   assign rx_push_dat = tx_pop ? tx_head : mem_if.in_rx_data;
`else
   assign rx_push_src = mem_if.in_rx_valid;
   assign rx_push_dat = mem_if.in_rx_data;
`endif

   assign rx_push    = rx_push_src && !rx_full_q;
   assign rx_pop     = !wr && uart_sel && (rx_count_q != '0);
   assign rx_count_d = rx_count_q + RCW'(rx_push) - RCW'(rx_pop);
   assign rx_full_d  = (rx_count_d == RCW'(RX_DEPTH));

   always_comb begin
      ram_rd_d = ram_rd_q;
      if (!wr) begin
         if (!io_sel)
            ram_rd_d = ram[ram_idx];
         else if (uart_sel)
            ram_rd_d = rx_pop ? rx_mem[rx_rd_ptr_q] : 8'h00;
         else if (halt_sel)
            ram_rd_d = {7'b0, (tx_count_q == '0)};
         else
            ram_rd_d = 8'h00;
      end
   end

   // Storage arrays carry no reset; pointer/count reset makes their contents dead.
   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_idx] <= mem_if.in_ram_data;
      if (tx_push)
         tx_mem[tx_wr_ptr_q] <= mem_if.in_ram_data;
      if (rx_push)
         rx_mem[rx_wr_ptr_q] <= rx_push_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_count_q  <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_count_q  <= '0;
         ram_rd_q    <= 8'h00;
         uart_full_q <= 1'b0;
         rx_full_q   <= 1'b0;
         overflow_q  <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         if (tx_push)
            tx_wr_ptr_q <= tx_wr_ptr_q + TPW'(1);
         if (tx_pop)
            tx_rd_ptr_q <= tx_rd_ptr_q + TPW'(1);
         if (rx_push)
            rx_wr_ptr_q <= rx_wr_ptr_q + RPW'(1);
         if (rx_pop)
            rx_rd_ptr_q <= rx_rd_ptr_q + RPW'(1);
         tx_count_q  <= tx_count_d;
         rx_count_q  <= rx_count_d;
         ram_rd_q    <= ram_rd_d;
         uart_full_q <= uart_full_d;
         rx_full_q   <= rx_full_d;
         overflow_q  <= overflow_d;
         halt_q      <= halt_d;
      end
   end

   assign mem_if.out_ram_data  = ram_rd_q;
   assign mem_if.out_uart_full = uart_full_q;
   assign mem_if.out_tx_data   = tx_head;
   assign mem_if.out_tx_valid  = (tx_count_q != '0);
   assign mem_if.out_rx_full   = rx_full_q;
   assign mem_if.out_overflow  = overflow_q;
   assign mem_if.out_halt      = halt_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a queue-based scoreboard of RAM, FIFOs and flags.
module tb_mem_io_responder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_io_responder_if bus();

   mem_io_responder dut (
      .clk    (clk),
      .rst    (rst),
      .mem_if (bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] mem[int];
   bit         exp_ovf  = 1'b0;
   bit         exp_halt = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      tx_q.delete();
      rx_q.delete();
      rd_q.delete();
      exp_ovf  = 1'b0;
      exp_halt = 1'b0;
   endtask

   task automatic chk_flags();
      chk("uart_full", bus.out_uart_full, {7'b0, (tx_q.size() >= 7)});
      chk("tx_valid",  bus.out_tx_valid,  {7'b0, (tx_q.size() != 0)});
      chk("rx_full",   bus.out_rx_full,   {7'b0, (rx_q.size() == 8)});
      chk("overflow",  bus.out_overflow,  {7'b0, exp_ovf});
      chk("halt",      bus.out_halt,      {7'b0, exp_halt});
   endtask

   // One bus cycle: drive inputs, update the model, clock, then compare.
   task automatic step(input logic wr, input logic [31:0] addr, input logic [7:0] d,
                       input logic rxv, input logic [7:0] rxd, input logic rdy);
      bit         io, rd_chk, lb_v, rx_full_pre, tx_empty_pre;
      logic [7:0] exp_rd, lb;
      bus.in_ram_write_flag = wr;
      bus.in_ram_address    = addr;
      bus.in_ram_data       = d;
      bus.in_rx_valid       = rxv;
      bus.in_rx_data        = rxd;
      bus.in_tx_ready       = rdy;
      io           = (addr[17:16] == 2'b11);
      rx_full_pre  = (rx_q.size() == 8);
      tx_empty_pre = (tx_q.size() == 0);
      rd_chk       = 1'b0;
      exp_rd       = 8'h00;
      lb           = 8'h00;
      lb_v         = 1'b0;
      if (!wr) begin
         if (!io) begin
            if (mem.exists(int'(addr[16:0]))) begin
               rd_chk = 1'b1;
               exp_rd = mem[int'(addr[16:0])];
            end
         end else begin
            rd_chk = 1'b1;
            if (addr[15:0] == 16'h0000)
               exp_rd = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            else if (addr[15:0] == 16'h0004)
               exp_rd = {7'b0, tx_empty_pre};
         end
         if (rd_chk)
            rd_q.push_back(exp_rd);
      end else if (!io) begin
         mem[int'(addr[16:0])] = d;
      end else if (addr[15:0] == 16'h0004) begin
         exp_halt = 1'b1;
      end
      if (rdy && tx_q.size() != 0) begin
         chk("tx_data", bus.out_tx_data, tx_q[0]);
         lb   = tx_q.pop_front();
         lb_v = 1'b1;
      end
      if (wr && io && addr[15:0] == 16'h0000) begin
         if (tx_q.size() < 8)
            tx_q.push_back(d);
         else
            exp_ovf = 1'b1;
      end
`ifdef TX_LOOPBACK_EN
      if (lb_v) begin
         if (!rx_full_pre)
            rx_q.push_back(lb);
      end else if (rxv && !rx_full_pre) begin
         rx_q.push_back(rxd);
      end
`else
      if (rxv && !rx_full_pre)
         rx_q.push_back(rxd);
`endif
      @(posedge clk);
      #1;
      if (rd_chk)
         chk("rd_data", bus.out_ram_data, rd_q.pop_front());
      chk_flags();
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, rdy);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1 model_clear();
      chk("rst_rd_data", bus.out_ram_data, 8'h00);
      chk_flags();
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.in_ram_write_flag = 1'b0;
      bus.in_ram_address    = 32'h0;
      bus.in_ram_data       = 8'h00;
      bus.in_tx_ready       = 1'b0;
      bus.in_rx_data        = 8'h00;
      bus.in_rx_valid       = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      chk("reset_rd_data", bus.out_ram_data, 8'h00);
      chk_flags();

      // RAM write/read, top index, write-cycle hold, status and unmapped IO
      step(1'b1, 32'h0000_0100, 8'hA5, 1'b0, 8'h00, 1'b0);
      step(1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b1, 32'h0001_FFFF, 8'h5A, 1'b0, 8'h00, 1'b0);
      step(1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b1, 32'h0000_0200, 8'h77, 1'b0, 8'h00, 1'b0);
      chk("write_holds_rd", bus.out_ram_data, 8'h5A);
      step(1'b0, 32'h0003_0004, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b1, 32'h0003_0008, 8'h99, 1'b0, 8'h00, 1'b0);
      step(1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 1'b0);

      // RX: two bytes then underflow read
      idle(1'b0);
      step(1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h31, 1'b0);
      step(1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h32, 1'b0);
      repeat (3) step(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0);

      // RX fill past full, drain past empty
      for (int i = 0; i < 9; i++)
         step(1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 9; i++)
         step(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0);

      // RX one-entry pop with simultaneous push
      step(1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h70, 1'b0);
      step(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h71, 1'b0);
      repeat (2) step(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0);

      // TX: fill with ready low, overflow on the ninth, then drain
      for (int i = 0; i < 9; i++)
         step(1'b1, 32'h0003_0000, 8'(8'h41 + i), 1'b0, 8'h00, 1'b0);
      step(1'b0, 32'h0003_0004, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 9; i++)
         idle(1'b1);

      // Halt, then asynchronous reset mid-cycle
      step(1'b1, 32'h0003_0004, 8'hEE, 1'b0, 8'h00, 1'b0);
      idle(1'b0);
      #2 rst = 1'b1;
      #1 model_clear();
      chk("async_rst_rd", bus.out_ram_data, 8'h00);
      chk_flags();
      #3 rst = 1'b0;
      idle(1'b0);

      // Full TX FIFO with simultaneous pop and push: no overflow
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'h0003_0000, 8'(8'h81 + i), 1'b0, 8'h00, 1'b0);
      step(1'b1, 32'h0003_0000, 8'h89, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 9; i++)
         idle(1'b1);

      do_reset();

      // Loopback observation: read RX after a TX byte leaves
      step(1'b1, 32'h0003_0000, 8'h55, 1'b0, 8'h00, 1'b1);
      idle(1'b1);
      step(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef TX_LOOPBACK_EN
      chk("loopback_rd", bus.out_ram_data, 8'h55);
`else
      chk("no_loopback_rd", bus.out_ram_data, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
